// File: rtl/taxi_axis_pkg.sv
// Shared AXI4-Stream definitions: frame-routing FSM states and index-width helper.
package taxi_axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } tid_demux_state_t;

  // Width of a port index for `count` ports; never narrower than one bit.
  function automatic int idx_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// AXI4-Stream interface bundle; optional sideband widths are carried as interface parameters.
interface taxi_axis_if #(
  parameter int   DATA_W  = 8,
  parameter logic KEEP_EN = (DATA_W > 8),
  parameter int   KEEP_W  = (DATA_W + 7) / 8,
  parameter logic STRB_EN = 1'b0,
  parameter logic LAST_EN = 1'b1,
  parameter logic ID_EN   = 1'b0,
  parameter int   ID_W    = 8,
  parameter logic DEST_EN = 1'b0,
  parameter int   DEST_W  = 8,
  parameter logic USER_EN = 1'b0,
  parameter int   USER_W  = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, input tready);
  modport snk (input tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_axis_skid_idx.sv
// Two-entry skid buffer (output + temp register) carrying a beat payload and its port index.
// One cycle of latency, full throughput, and a registered s_ready.
module taxi_axis_skid_idx #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [IDX_W-1:0]  s_idx,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_idx
);
  logic              temp_valid;
  logic [DATA_W-1:0] temp_data;
  logic [IDX_W-1:0]  temp_idx;
  logic              s_ready_early;
  logic              out_load_in;
  logic              out_load_temp;
  logic              temp_load;

  // Ready next cycle only if the temp entry is guaranteed to be empty then.
  assign s_ready_early = m_ready || (!temp_valid && (!m_valid || !s_valid));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    out_load_in   = 1'b0;
    out_load_temp = 1'b0;
    temp_load     = 1'b0;
    if (s_ready) begin
      if (m_ready || !m_valid) begin
        out_load_in = 1'b1;
      end else begin
        temp_load = s_valid;
      end
    end else if (m_ready) begin
      out_load_temp = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      temp_valid <= 1'b0;
    end else begin
      s_ready <= s_ready_early;
      if (out_load_in) begin
        m_valid <= s_valid;
      end else if (out_load_temp) begin
        m_valid    <= temp_valid;
        temp_valid <= 1'b0;
      end
      if (temp_load) begin
        temp_valid <= 1'b1;
      end
    end
  end

  // NOTE: payload registers are qualified by the valid flags, so they carry no reset.
  always_ff @(posedge clk) begin
    if (out_load_in) begin
      m_data <= s_data;
      m_idx  <= s_idx;
    end else if (out_load_temp) begin
      m_data <= temp_data;
      m_idx  <= temp_idx;
    end
    if (temp_load) begin
      temp_data <= s_data;
      temp_idx  <= s_idx;
    end
  end

endmodule

// File: rtl/taxi_axis_tid_demux.sv
// AXI4-Stream demultiplexer: whole frames are routed to m_axis[n] by the top bits of tid.
// Frames with an out-of-range index are swallowed and reported with a stat_drop pulse.
module taxi_axis_tid_demux
  import taxi_axis_pkg::*;
#(
  parameter int   M_COUNT   = 4,
  parameter logic STRIP_TID = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  taxi_axis_if.snk s_axis,
  taxi_axis_if.src m_axis [M_COUNT],
  output logic     stat_drop
);
  localparam int   DATA_W     = s_axis.DATA_W;
  localparam int   KEEP_W     = s_axis.KEEP_W;
  localparam logic LAST_EN    = s_axis.LAST_EN;
  localparam logic ID_EN      = s_axis.ID_EN;
  localparam int   ID_W       = s_axis.ID_W;
  localparam int   DEST_W     = s_axis.DEST_W;
  localparam int   USER_W     = s_axis.USER_W;
  localparam int   CL_M_COUNT = idx_w(M_COUNT);
  localparam int   PAD_COUNT  = 1 << CL_M_COUNT;

  if (M_COUNT < 2 || M_COUNT > 16) begin : g_chk_count
    $fatal(0, "Error: M_COUNT must be 2..16 (instance %m)");
  end
  if (m_axis[0].DATA_W != DATA_W) begin : g_chk_data
    $fatal(0, "Error: interface DATA_W parameter mismatch (instance %m)");
  end
  if (m_axis[0].KEEP_W != KEEP_W) begin : g_chk_keep
    $fatal(0, "Error: interface KEEP_W parameter mismatch (instance %m)");
  end
  if (!ID_EN) begin : g_chk_id_en
    $fatal(0, "Error: s_axis ID_EN must be set for tid routing (instance %m)");
  end
  if (ID_W < CL_M_COUNT) begin : g_chk_id_w
    $fatal(0, "Error: s_axis ID_W too narrow for M_COUNT (instance %m)");
  end

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;
  } beat_t;

  tid_demux_state_t      state;
  logic [CL_M_COUNT-1:0] route_idx;
  logic [CL_M_COUNT-1:0] sel_idx;
  logic                  first_beat;
  logic                  in_range;
  logic                  beat_last;
  logic                  fwd;
  logic                  s_xfer;
  logic                  skid_s_ready;
  beat_t                 in_beat;
  beat_t                 out_beat;
  logic                  out_valid;
  logic [CL_M_COUNT-1:0] out_idx;
  logic                  out_ready;
  logic [PAD_COUNT-1:0]  m_tready;

  // The index is only looked at on a frame's first beat; later beats follow the latched route.
  assign first_beat = (state == ST_IDLE);
  assign sel_idx    = first_beat ? s_axis.tid[ID_W-1 -: CL_M_COUNT] : route_idx;
  assign in_range   = int'(sel_idx) < M_COUNT;
  assign beat_last  = LAST_EN ? s_axis.tlast : 1'b1;
  assign fwd        = (state == ST_FWD) || (first_beat && in_range);
  assign s_xfer     = s_axis.tvalid && skid_s_ready;

  assign s_axis.tready = skid_s_ready;

  always_comb begin
    in_beat = '{tdata: s_axis.tdata, tkeep: s_axis.tkeep, tstrb: s_axis.tstrb,
                tlast: beat_last, tid: s_axis.tid, tdest: s_axis.tdest, tuser: s_axis.tuser};
    if (STRIP_TID) begin
      in_beat.tid[ID_W-1 -: CL_M_COUNT] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      stat_drop <= 1'b0;
    end else begin
      stat_drop <= s_xfer && beat_last && !fwd;
      case (state)
        ST_IDLE: begin
          if (s_xfer && !beat_last) begin
            state <= in_range ? ST_FWD : ST_DROP;
          end
        end
        ST_FWD, ST_DROP: begin
          if (s_xfer && beat_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (first_beat && s_xfer) begin
      route_idx <= sel_idx;
    end
  end

  taxi_axis_skid_idx #(
    .DATA_W ($bits(beat_t)),
    .IDX_W  (CL_M_COUNT)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_axis.tvalid && fwd),
    .s_ready (skid_s_ready),
    .s_data  (in_beat),
    .s_idx   (sel_idx),
    .m_valid (out_valid),
    .m_ready (out_ready),
    .m_data  (out_beat),
    .m_idx   (out_idx)
  );

  // Unused index codes read as not-ready so a stray index can never advance the buffer.
  assign out_ready = m_tready[out_idx];

  for (genvar n = 0; n < M_COUNT; n++) begin : g_port
    assign m_axis[n].tdata  = out_beat.tdata;
    assign m_axis[n].tkeep  = out_beat.tkeep;
    assign m_axis[n].tstrb  = out_beat.tstrb;
    assign m_axis[n].tlast  = out_beat.tlast;
    assign m_axis[n].tid    = out_beat.tid;
    assign m_axis[n].tdest  = out_beat.tdest;
    assign m_axis[n].tuser  = out_beat.tuser;
    assign m_axis[n].tvalid = out_valid && (out_idx == CL_M_COUNT'(n));
    assign m_tready[n]      = m_axis[n].tready;
  end

  for (genvar n = M_COUNT; n < PAD_COUNT; n++) begin : g_pad
    assign m_tready[n] = 1'b0;
  end

endmodule

// File: doc/taxi_axis_tid_demux.md
TAXI_AXIS_TID_DEMUX -- requirements
Module: taxi_axis_tid_demux

Interface
REQ-001 SHALL have parameter M_COUNT, default 4: number of AXI4-Stream outputs, 2..16.
REQ-002 SHALL have parameter STRIP_TID, default 1'b1: if set, routing bits in output tid are zeroed.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 SHALL have port s_axis  taxi_axis_if.snk  -  input stream; routing index in upper CL_M_COUNT=$clog2(M_COUNT) bits of tid.
REQ-006 SHALL have port m_axis[M_COUNT]  taxi_axis_if.src  -  output streams.
REQ-007 SHALL have port stat_drop  output  1  one-cycle pulse per frame discarded for out-of-range index.
REQ-008 SHALL fail elaboration ($fatal) on DATA_W/KEEP_W mismatch, ID_EN clear, or s_axis ID_W < CL_M_COUNT.

Function
REQ-009 SHALL route whole frames; index sampled on the first beat of a frame (state IDLE) and held until the tlast beat is accepted.
REQ-010 SHALL implement FSM states IDLE, FWD, DROP; IDLE->FWD on accepted non-last first beat with index<M_COUNT; IDLE->DROP on accepted non-last first beat with index>=M_COUNT; FWD/DROP->IDLE on accepted tlast beat; single-beat frames stay in IDLE.
REQ-011 SHALL ignore tid index on non-first beats; mid-frame index change does not alter route.
REQ-012 SHALL treat every beat as last when LAST_EN is clear.
REQ-013 SHALL forward through a 2-entry skid buffer (output reg + temp reg), each entry storing beat fields plus port index; latency exactly 1 cycle, sustained 1 beat/cycle.
REQ-014 SHALL drive m_axis[n].tvalid = output entry valid AND entry port == n; all other ports' tvalid 0.
REQ-015 SHALL drive s_axis.tready from a register: 1 when temp entry will be empty next cycle.
REQ-016 SHALL in DROP (and on an index>=M_COUNT first beat) accept beats with tready per REQ-015 and discard them; stat_drop pulses on the tlast beat of the dropped frame.
REQ-017 SHALL pass tdata, tkeep, tstrb, tlast, tdest, tuser unchanged; tid passed with upper CL_M_COUNT bits zeroed when STRIP_TID set.
REQ-018 SHALL, on simultaneous output accept and input accept, move temp->output or input->output with no bubble and no reorder.
REQ-019 SHALL never present tvalid on two ports in the same cycle.

Reset
REQ-020 SHALL on rst low: all m_axis tvalid 0, s_axis.tready 0, stat_drop 0, FSM IDLE, both skid entries invalid; data registers not reset.
REQ-021 SHALL drive s_axis.tready 1 on the first clk edge after rst deasserts.
REQ-022 SHALL, on reset mid-frame, discard the partial frame; the next accepted beat is a first beat.

Structure
REQ-023 SHALL place the FSM state enum in shared package taxi_axis_pkg.
REQ-024 SHALL place the skid buffer in sub-module taxi_axis_skid_idx (beat fields + index, parameterised width).
REQ-025 SHALL be 120-400 lines of RTL total.

Verification
REQ-026 Frame 4 beats, tid=0x80 (ID_W=8, M_COUNT=4 -> port 2), m_axis[2].tready=1 -> 4 beats on port 2 one cycle after each input, tid=0x00, other ports idle.
REQ-027 Back-to-back 1-beat frames to ports 0,1,2,3, all outputs ready -> one beat per cycle in order, stat_drop never pulses.
REQ-028 Frame to port 1, m_axis[1].tready held 0 for 5 cycles after 2 beats -> s_axis.tready falls within 2 cycles, no beat lost/duplicated after release.
REQ-029 M_COUNT=3, 3-beat frame with index 3 -> no output tvalid, stat_drop pulses once on the tlast accept, next frame to port 0 forwarded normally.
REQ-030 Frame to port 0 with tid index changed to 3 on beat 2 -> all beats on port 0.
REQ-031 rst low during beat 2 of a 4-beat frame, then new 2-beat frame to port 3 -> outputs invalid during reset, new frame fully on port 3.
